leds_out_pio: RTL and testbench

//  Avalon-MM slave output PIO that drives board LEDs from the Nios II data master.

---
 rtl/leds_out_pio.sv | 104 ++++++++++
 tb/tb_leds_out_pio.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/leds_out_pio.sv
// Avalon-MM output PIO driving board LEDs: data register with set/clear aliases,
// per-bit blink mask, and a prescaled blink phase gating the masked bits.
module leds_out_pio #(
  parameter int          WIDTH       = 8,
  parameter int          BLINK_DIV   = 25000000,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam int               CNT_W    = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
  localparam logic [WIDTH-1:0] RST_DATA = RESET_VALUE[WIDTH-1:0];

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_BLINK  = 2'd1;
  localparam logic [1:0] ADDR_OUTSET = 2'd2;
  localparam logic [1:0] ADDR_OUTCLR = 2'd3;

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_blink;
  logic [CNT_W-1:0] r_cnt;
  logic             r_phase;

  logic             w_wr;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] w_data_next;
  logic [31:0]      w_rd_mux;
  logic             w_cnt_last;
  logic             w_unused;

  // Bus: a write is taken on any edge where chipselect=1 and write_n=0 (no wait
  // states); reads carry no strobe, readdata is the registered mux of address.
  assign w_wr       = chipselect & ~write_n;
  assign w_wd       = writedata[WIDTH-1:0];
  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_unused   = &{1'b0, writedata};

  always_comb begin
    w_data_next = r_data;
    if (w_wr) begin
      case (address)
        ADDR_DATA:   w_data_next = w_wd;
        ADDR_OUTSET: w_data_next = r_data | w_wd;
        ADDR_OUTCLR: w_data_next = r_data & ~w_wd;
        default:     w_data_next = r_data;
      endcase
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA:   w_rd_mux[WIDTH-1:0] = r_data;
      ADDR_BLINK:  w_rd_mux[WIDTH-1:0] = r_blink;
      ADDR_OUTSET: w_rd_mux[0]         = r_phase;
      default:     w_rd_mux            = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= RST_DATA;
      r_blink <= '0;
    end else begin
      r_data <= w_data_next;
      if (w_wr && address == ADDR_BLINK) r_blink <= w_wd;
    end
  end

  // A BLINK write restarts the period in the lit phase, winning over terminal count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (w_wr && address == ADDR_BLINK) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (w_cnt_last) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
      out_port <= RST_DATA;
    end else begin
      readdata <= w_rd_mux;
      out_port <= r_data & (~r_blink | {WIDTH{r_phase}});
    end
  end

endmodule

// File: tb/tb_leds_out_pio.sv
// Directed bench for leds_out_pio with WIDTH=8, BLINK_DIV=4.
module tb_leds_out_pio;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int n_pass  = 0;
  int n_total = 0;

  leds_out_pio #(
    .WIDTH       (8),
    .BLINK_DIV   (4),
    .RESET_VALUE (32'h0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  // Driver tasks: inputs change and outputs are sampled 1 time unit after posedge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    @(posedge clk); #1;
    d = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (out_port !== 8'h00) $display("FAIL reset_out_port got=%h exp=%h", out_port, 8'h00);
    else n_pass++;
    n_total++;
    if (readdata !== 32'h0) $display("FAIL reset_readdata got=%h exp=%h", readdata, 32'h0);
    else n_pass++;
    reset = 1'b0;
    bus_read(2'd2, rd);
    n_total++;
    if (rd !== 32'h1) $display("FAIL reset_phase_read got=%h exp=%h", rd, 32'h1);
    else n_pass++;
    bus_read(2'd3, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL outclr_read got=%h exp=%h", rd, 32'h0);
    else n_pass++;
  endtask

  task automatic test_data_write();
    logic [31:0] rd;
    bus_write(2'd0, 32'hA5);
    n_total++;
    if (out_port !== 8'h00) $display("FAIL data_pins_early got=%h exp=%h", out_port, 8'h00);
    else n_pass++;
    bus_read(2'd0, rd);
    n_total++;
    if (rd !== 32'h000000A5) $display("FAIL data_readback got=%h exp=%h", rd, 32'h000000A5);
    else n_pass++;
    n_total++;
    if (out_port !== 8'hA5) $display("FAIL data_pins got=%h exp=%h", out_port, 8'hA5);
    else n_pass++;
  endtask

  task automatic test_set_clr();
    logic [31:0] rd;
    bus_write(2'd1, 32'h3C);
    bus_write(2'd2, 32'h0F);
    bus_read(2'd0, rd);
    n_total++;
    if (rd !== 32'hAF) $display("FAIL outset got=%h exp=%h", rd, 32'hAF);
    else n_pass++;
    bus_write(2'd3, 32'hA0);
    bus_read(2'd0, rd);
    n_total++;
    if (rd !== 32'h0F) $display("FAIL outclr got=%h exp=%h", rd, 32'h0F);
    else n_pass++;
    bus_read(2'd1, rd);
    n_total++;
    if (rd !== 32'h3C) $display("FAIL blink_kept got=%h exp=%h", rd, 32'h3C);
    else n_pass++;
    bus_write(2'd1, 32'h0);
    bus_write(2'd0, 32'hFFFFFF00);
    bus_read(2'd0, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL upper_bits_ignored got=%h exp=%h", rd, 32'h0);
    else n_pass++;
  endtask

  task automatic test_blink();
    logic [7:0] exp_v;
    bus_write(2'd0, 32'hFF);
    bus_write(2'd1, 32'hF0);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      exp_v = (((k - 1) / 4) % 2 == 0) ? 8'hFF : 8'h0F;
      n_total++;
      if (out_port !== exp_v) $display("FAIL blink_cycle%0d got=%h exp=%h", k, out_port, exp_v);
      else n_pass++;
    end
    // Now in the dark half-period; restart must give a full lit period.
    bus_write(2'd1, 32'hF0);
    n_total++;
    if (out_port !== 8'h0F) $display("FAIL restart_edge got=%h exp=%h", out_port, 8'h0F);
    else n_pass++;
    for (int j = 1; j <= 5; j++) begin
      @(posedge clk); #1;
      exp_v = (j <= 4) ? 8'hFF : 8'h0F;
      n_total++;
      if (out_port !== exp_v) $display("FAIL restart_cycle%0d got=%h exp=%h", j, out_port, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_blink();
    logic [31:0] rd;
    reset      = 1'b1;
    address    = 2'd0;
    writedata  = 32'h55;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (out_port !== 8'h00) $display("FAIL rst_blink_pins got=%h exp=%h", out_port, 8'h00);
    else n_pass++;
    n_total++;
    if (readdata !== 32'h0) $display("FAIL rst_blink_readdata got=%h exp=%h", readdata, 32'h0);
    else n_pass++;
    reset      = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    bus_read(2'd2, rd);
    n_total++;
    if (rd !== 32'h1) $display("FAIL rst_blink_phase got=%h exp=%h", rd, 32'h1);
    else n_pass++;
    bus_read(2'd1, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL rst_blink_mask got=%h exp=%h", rd, 32'h0);
    else n_pass++;
    bus_read(2'd0, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL rst_write_lost got=%h exp=%h", rd, 32'h0);
    else n_pass++;
    n_total++;
    if (out_port !== 8'h00) $display("FAIL rst_pins_after got=%h exp=%h", out_port, 8'h00);
    else n_pass++;
  endtask

  task automatic test_ignored_writes();
    logic [31:0] rd;
    bus_write(2'd0, 32'h5A);
    bus_write(2'd1, 32'h81);
    address    = 2'd0;
    writedata  = 32'hFF;
    chipselect = 1'b0;
    write_n    = 1'b0;
    @(posedge clk); #1;
    address    = 2'd1;
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(posedge clk); #1;
    chipselect = 1'b0;
    writedata  = 32'h0;
    bus_read(2'd0, rd);
    n_total++;
    if (rd !== 32'h5A) $display("FAIL no_cs_write got=%h exp=%h", rd, 32'h5A);
    else n_pass++;
    bus_read(2'd1, rd);
    n_total++;
    if (rd !== 32'h81) $display("FAIL no_wr_write got=%h exp=%h", rd, 32'h81);
    else n_pass++;
  endtask

  initial begin
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    @(posedge clk); #1;
    test_reset();
    test_data_write();
    test_set_clr();
    test_blink();
    test_reset_mid_blink();
    test_ignored_writes();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
